// File: rtl/mem_ctrl.sv
// rtl/mem_ctrl.sv - byte-serial RAM port arbiter/sequencer for IF fetches and MEM loads/stores.
// Optional MEMCTRL_RR_EN: round-robin grant between IF and MEM instead of fixed MEM priority.
module mem_ctrl #(
   parameter int ADDR_W = 32
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              if_req,
   input  logic [ADDR_W-1:0] if_addr,
   output logic              if_rdy,
   output logic [31:0]       if_data,
   input  logic              ls_req,
   input  logic              ls_we,
   input  logic [1:0]        ls_size,
   input  logic [ADDR_W-1:0] ls_addr,
   input  logic [31:0]       ls_wdata,
   output logic              ls_rdy,
   output logic [31:0]       ls_rdata,
   input  logic              flush,
   output logic [ADDR_W-1:0] ram_addr,
   output logic              ram_wr,
   output logic [7:0]        ram_dout,
   input  logic [7:0]        ram_din,
   output logic              busy
);

   typedef enum logic [2:0] {IDLE, IF_RD, LS_RD, LS_WR, DONE} state_t;

   state_t            state, next_state;
   logic [2:0]        cnt;
   logic [2:0]        size_n;
   logic [ADDR_W-1:0] base;
   logic [31:0]       wdata;
   logic [31:0]       data;
   logic              src_if;
   logic              if_rdy_q;

   logic              if_pend, grant_ls, grant_if;
   logic [2:0]        ls_n;
   logic [1:0]        bi;
   logic [ADDR_W-1:0] ram_addr_d;
   logic              ram_wr_d, if_rdy_d, ls_rdy_d;
   logic [7:0]        ram_dout_d;
   logic [31:0]       data_d;

   assign if_pend = if_req & ~flush;
   assign ls_n    = (ls_size == 2'd0) ? 3'd1 : (ls_size == 2'd1) ? 3'd2 : 3'd4;
   assign bi      = 2'(cnt - 3'd2);

`ifdef MEMCTRL_RR_EN
   logic last_if;
   assign grant_ls = ls_req & (~if_pend | last_if);

   always_ff @(posedge clk) begin
      if (rst)
         last_if <= 1'b1;
      else if (state == IDLE && (grant_ls || grant_if))
         last_if <= grant_if;
   end
`else
   assign grant_ls = ls_req;
`endif
   assign grant_if = if_pend & ~grant_ls;

   always_ff @(posedge clk) begin
      if (rst)
         state <= IDLE;
      else
         state <= next_state;
   end

   always_comb begin
      next_state = state;
      case (state)
         IDLE:    if (grant_ls)      next_state = ls_we ? LS_WR : LS_RD;
                  else if (grant_if) next_state = IF_RD;
         IF_RD:   if (flush)                        next_state = IDLE;
                  else if (cnt == size_n + 3'd1)    next_state = DONE;
         LS_RD:   if (cnt == size_n + 3'd1)         next_state = DONE;
         LS_WR:   if (cnt == size_n)                next_state = DONE;
         DONE:    next_state = IDLE;
         default: next_state = IDLE;
      endcase
   end

   // Values the registered outputs take in the next cycle.
   always_comb begin
      ram_addr_d = '0;
      ram_wr_d   = 1'b0;
      ram_dout_d = 8'd0;
      if_rdy_d   = 1'b0;
      ls_rdy_d   = 1'b0;
      data_d     = data;
      case (state)
         IDLE: begin
            if (grant_ls) begin
               ram_addr_d = ls_addr;
               ram_wr_d   = ls_we;
               ram_dout_d = ls_we ? ls_wdata[7:0] : 8'd0;
               data_d     = '0;
            end else if (grant_if) begin
               ram_addr_d = if_addr;
               data_d     = '0;
            end
         end
         IF_RD, LS_RD: begin
            if (!(state == IF_RD && flush)) begin
               // RAM read data lags the address by one cycle.
               if (cnt >= 3'd2)
                  data_d[{bi, 3'b000} +: 8] = ram_din;
               if (cnt < size_n)
                  ram_addr_d = base + ADDR_W'(cnt);
               if (next_state == DONE) begin
                  if_rdy_d = src_if;
                  ls_rdy_d = ~src_if;
               end
            end
         end
         LS_WR: begin
            if (cnt < size_n) begin
               ram_addr_d = base + ADDR_W'(cnt);
               ram_wr_d   = 1'b1;
               ram_dout_d = wdata[{cnt[1:0], 3'b000} +: 8];
            end else begin
               ls_rdy_d = 1'b1;
            end
         end
         default: ;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         cnt      <= 3'd0;
         size_n   <= 3'd0;
         base     <= '0;
         wdata    <= '0;
         data     <= '0;
         src_if   <= 1'b0;
         ram_addr <= '0;
         ram_wr   <= 1'b0;
         ram_dout <= 8'd0;
         if_rdy_q <= 1'b0;
         ls_rdy   <= 1'b0;
         if_data  <= '0;
         ls_rdata <= '0;
         busy     <= 1'b0;
      end else begin
         ram_addr <= ram_addr_d;
         ram_wr   <= ram_wr_d;
         ram_dout <= ram_dout_d;
         if_rdy_q <= if_rdy_d;
         ls_rdy   <= ls_rdy_d;
         data     <= data_d;
         busy     <= (next_state != IDLE);
         if (next_state == IF_RD || next_state == LS_RD || next_state == LS_WR)
            cnt <= cnt + 3'd1;
         else
            cnt <= 3'd0;
         if (state == IDLE && grant_ls) begin
            base   <= ls_addr;
            size_n <= ls_n;
            wdata  <= ls_wdata;
            src_if <= 1'b0;
         end else if (state == IDLE && grant_if) begin
            base   <= if_addr;
            size_n <= 3'd4;
            src_if <= 1'b1;
         end
         if (if_rdy_d)
            if_data <= data_d;
         if (ls_rdy_d && state == LS_RD)
            ls_rdata <= data_d;
      end
   end

   // A flush landing on the completion cycle still suppresses the fetch handshake.
   assign if_rdy = if_rdy_q & ~flush;

endmodule
